// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side signal bundle for the forwarding / hazard unit.
// The pipeline drives the master side; the hazard unit sits on the slave side.
interface fwd_hazard_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int MAX_MC  = 4,
    parameter int CW      = 16
);
    localparam int MCW = $clog2(MAX_MC + 1);

    logic                   id_valid;
    logic [NUM_SRC*AW-1:0]  id_rs;
    logic [NUM_SRC-1:0]     id_rs_used;
    logic [AW-1:0]          id_rd;
    logic                   id_regwrite;
    logic                   id_is_mc;
    logic [NUM_SRC*AW-1:0]  ex_rs;
    logic [AW-1:0]          id_ex_rd;
    logic                   id_ex_memread;
    logic [AW-1:0]          ex_mem_rd;
    logic                   ex_mem_regwrite;
    logic [AW-1:0]          mem_wb_rd;
    logic                   mem_wb_regwrite;
    logic                   mc_wb;
    logic [AW-1:0]          mc_wb_rd;

    logic [2*NUM_SRC-1:0]   fwd_sel;
    logic                   stall_id;
    logic                   bubble_ex;
    logic [(1<<AW)-1:0]     busy_vec;
    logic [MCW-1:0]         mc_count;
    logic [CW-1:0]          stall_cnt;
    logic                   err;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_mc,
               ex_rs, id_ex_rd, id_ex_memread, ex_mem_rd, ex_mem_regwrite,
               mem_wb_rd, mem_wb_regwrite, mc_wb, mc_wb_rd,
        input  fwd_sel, stall_id, bubble_ex, busy_vec, mc_count, stall_cnt, err
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_mc,
               ex_rs, id_ex_rd, id_ex_memread, ex_mem_rd, ex_mem_regwrite,
               mem_wb_rd, mem_wb_regwrite, mc_wb, mc_wb_rd,
        output fwd_sel, stall_id, bubble_ex, busy_vec, mc_count, stall_cnt, err
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, ID-stage stall detection and multicycle-op scoreboard
// for an in-order pipeline with an out-of-band mul/div unit.
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int MAX_MC  = 4,
    parameter int CW      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  hz
);
    localparam int NREG = 1 << AW;
    localparam int MCW  = $clog2(MAX_MC + 1);

    logic [NREG-1:0]      busy_reg, busy_next;
    logic [MCW-1:0]       mc_count_reg, mc_count_next;
    logic [CW-1:0]        stall_cnt_reg, stall_cnt_next;
    logic                 err_reg, err_next;

    logic [2*NUM_SRC-1:0] fwd_sel;
    logic                 load_use, raw_haz, waw_haz, struct_haz, stall;
    logic                 issue, wb_err, wb_ok;

    // Per-port forwarding: youngest producer (EX/MEM) wins, then the multicycle
    // writeback, then MEM/WB. x0 is never forwarded.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            logic [AW-1:0] rs;
            logic [1:0]    sel;
            assign rs = hz.ex_rs[gi*AW +: AW];
            always_comb begin
                sel = 2'b00;
                if (rs != '0) begin
                    if (hz.ex_mem_regwrite && hz.ex_mem_rd == rs)
                        sel = 2'b10;
                    else if (hz.mc_wb && hz.mc_wb_rd == rs)
                        sel = 2'b11;
                    else if (hz.mem_wb_regwrite && hz.mem_wb_rd == rs)
                        sel = 2'b01;
                end
            end
            assign fwd_sel[2*gi +: 2] = sel;
        end
    endgenerate

    // Hazards read the registered scoreboard only, so a writeback in this cycle
    // does not release a dependent instruction until the following cycle.
    always_comb begin
        load_use = 1'b0;
        raw_haz  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.id_rs_used[i]) begin
                if (hz.id_ex_rd != '0 && hz.id_ex_rd == hz.id_rs[i*AW +: AW])
                    load_use = 1'b1;
                if (busy_reg[hz.id_rs[i*AW +: AW]])
                    raw_haz = 1'b1;
            end
        end
        load_use = load_use & hz.id_valid & hz.id_ex_memread;
        raw_haz  = raw_haz & hz.id_valid;
    end

    assign waw_haz    = hz.id_valid && hz.id_regwrite && (hz.id_rd != '0) && busy_reg[hz.id_rd];
    assign struct_haz = hz.id_valid && hz.id_is_mc && (mc_count_reg == MCW'(MAX_MC));
    assign stall      = load_use | raw_haz | waw_haz | struct_haz;

    assign issue  = hz.id_valid && hz.id_is_mc && hz.id_regwrite && !stall;
    // A writeback with nothing outstanding, or to a register not awaiting a
    // result, is a protocol violation and leaves the scoreboard untouched.
    assign wb_err = hz.mc_wb && ((mc_count_reg == '0) ||
                                 (hz.mc_wb_rd != '0 && !busy_reg[hz.mc_wb_rd]));
    assign wb_ok  = hz.mc_wb && !wb_err;

    always_comb begin
        busy_next = busy_reg;
        if (wb_ok)
            busy_next[hz.mc_wb_rd] = 1'b0;
        if (issue)
            busy_next[hz.id_rd] = 1'b1;
        busy_next[0] = 1'b0;

        mc_count_next = mc_count_reg;
        case ({issue, wb_ok})
            2'b10:   mc_count_next = mc_count_reg + 1'b1;
            2'b01:   mc_count_next = mc_count_reg - 1'b1;
            default: mc_count_next = mc_count_reg;
        endcase

        stall_cnt_next = stall_cnt_reg;
        if (stall && stall_cnt_reg != '1)
            stall_cnt_next = stall_cnt_reg + 1'b1;

        err_next = err_reg | wb_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg      <= '0;
            mc_count_reg  <= '0;
            stall_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            busy_reg      <= busy_next;
            mc_count_reg  <= mc_count_next;
            stall_cnt_reg <= stall_cnt_next;
            err_reg       <= err_next;
        end
    end

    assign hz.fwd_sel   = fwd_sel;
    assign hz.stall_id  = stall;
    assign hz.bubble_ex = stall;
    assign hz.busy_vec  = busy_reg;
    assign hz.mc_count  = mc_count_reg;
    assign hz.stall_cnt = stall_cnt_reg;
    assign hz.err       = err_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against an array-based model.
module tb_fwd_hazard_unit;
    localparam int NUM_SRC = 2;
    localparam int AW      = 5;
    localparam int MAX_MC  = 4;
    localparam int CW      = 4;
    localparam int NREG    = 1 << AW;
    localparam int SAT     = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NUM_SRC(NUM_SRC), .AW(AW), .MAX_MC(MAX_MC), .CW(CW)) bus ();

    fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .MAX_MC(MAX_MC), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference state
    bit m_busy [NREG];
    int m_cnt;
    int m_scnt;
    bit m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input int p);
        int rs;
        rs = int'(bus.ex_rs[p*AW +: AW]);
        if (rs == 0) return 2'b00;
        if (bus.ex_mem_regwrite && int'(bus.ex_mem_rd) == rs) return 2'b10;
        if (bus.mc_wb && int'(bus.mc_wb_rd) == rs) return 2'b11;
        if (bus.mem_wb_regwrite && int'(bus.mem_wb_rd) == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_stall();
        bit s;
        int rs;
        s = 0;
        if (!bus.id_valid) return 0;
        for (int p = 0; p < NUM_SRC; p++) begin
            rs = int'(bus.id_rs[p*AW +: AW]);
            if (bus.id_rs_used[p]) begin
                if (bus.id_ex_memread && bus.id_ex_rd != 0 && int'(bus.id_ex_rd) == rs) s = 1;
                if (m_busy[rs]) s = 1;
            end
        end
        if (bus.id_regwrite && bus.id_rd != 0 && m_busy[bus.id_rd]) s = 1;
        if (bus.id_is_mc && m_cnt == MAX_MC) s = 1;
        return s;
    endfunction

    function automatic logic [NREG-1:0] model_busy_vec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m_busy[r] = 0;
        m_cnt  = 0;
        m_scnt = 0;
        m_err  = 0;
    endtask

    task automatic idle();
        bus.id_valid        = 0;
        bus.id_rs           = '0;
        bus.id_rs_used      = '0;
        bus.id_rd           = '0;
        bus.id_regwrite     = 0;
        bus.id_is_mc        = 0;
        bus.ex_rs           = '0;
        bus.id_ex_rd        = '0;
        bus.id_ex_memread   = 0;
        bus.ex_mem_rd       = '0;
        bus.ex_mem_regwrite = 0;
        bus.mem_wb_rd       = '0;
        bus.mem_wb_regwrite = 0;
        bus.mc_wb           = 0;
        bus.mc_wb_rd        = '0;
    endtask

    task automatic check_state(input string tag);
        check({tag, " busy_vec"},  bus.busy_vec,  model_busy_vec());
        check({tag, " mc_count"},  bus.mc_count,  m_cnt);
        check({tag, " stall_cnt"}, bus.stall_cnt, m_scnt);
        check({tag, " err"},       bus.err,       m_err);
    endtask

    // Inputs are already driven (just after a rising edge). Checks the
    // combinational outputs, advances one clock and checks the state.
    task automatic step(input string tag);
        bit st, issue, bad;
        int wrd, ird;
        #2;
        st = model_stall();
        for (int p = 0; p < NUM_SRC; p++)
            check($sformatf("%s fwd%0d", tag, p), bus.fwd_sel[2*p +: 2], model_fwd(p));
        check({tag, " stall_id"},  bus.stall_id,  st);
        check({tag, " bubble_ex"}, bus.bubble_ex, st);
        issue = bus.id_valid && bus.id_is_mc && bus.id_regwrite && !st;
        wrd   = int'(bus.mc_wb_rd);
        ird   = int'(bus.id_rd);
        bad   = bus.mc_wb && (m_cnt == 0 || (wrd != 0 && !m_busy[wrd]));
        @(posedge clk);
        if (bad) m_err = 1;
        else if (bus.mc_wb) begin
            m_busy[wrd] = 0;
            m_cnt--;
        end
        if (issue) begin
            m_cnt++;
            if (ird != 0) m_busy[ird] = 1;
        end
        m_busy[0] = 0;
        if (st && m_scnt < SAT) m_scnt++;
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst_n = 0;
        #1;
        model_reset();
        check_state({tag, " async"});
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input int rd);
        idle();
        bus.id_valid    = 1;
        bus.id_is_mc    = 1;
        bus.id_regwrite = 1;
        bus.id_rd       = AW'(rd);
    endtask

    initial begin
        rst_n = 1;
        idle();
        model_reset();
        #1 rst_n = 0;
        #1;
        check_state("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Forwarding priority on EX port 0
        idle();
        bus.ex_rs = {5'd0, 5'd5};
        bus.ex_mem_rd = 5; bus.ex_mem_regwrite = 1;
        bus.mem_wb_rd = 5; bus.mem_wb_regwrite = 1;
        #1 check("fwd exmem", bus.fwd_sel[1:0], 2'b10);
        step("fwd_a");
        bus.ex_mem_regwrite = 0;
        #1 check("fwd memwb", bus.fwd_sel[1:0], 2'b01);
        step("fwd_b");
        bus.ex_rs = '0; bus.ex_mem_regwrite = 1;
        #1 check("fwd x0", bus.fwd_sel[1:0], 2'b00);
        step("fwd_c");

        // Load-use on port 1
        idle();
        bus.id_valid = 1; bus.id_ex_memread = 1; bus.id_ex_rd = 7;
        bus.id_rs = {5'd7, 5'd3}; bus.id_rs_used = 2'b11;
        #1 check("lu stall", bus.stall_id, 1'b1);
        step("lu_a");
        check("lu cnt", bus.stall_cnt, 1);
        bus.id_rs_used = 2'b01;
        #1 check("lu unused", bus.stall_id, 1'b0);
        step("lu_b");

        // Multicycle issue / RAW / writeback to x9
        set_issue(9);
        step("mc_iss");
        check("mc busy9", bus.busy_vec[9], 1'b1);
        check("mc cnt1", bus.mc_count, 1);
        idle();
        bus.id_valid = 1; bus.id_rs = {5'd0, 5'd9}; bus.id_rs_used = 2'b01;
        step("raw_a");
        step("raw_b");
        bus.mc_wb = 1; bus.mc_wb_rd = 9; bus.ex_rs = {5'd0, 5'd9};
        #1 check("raw wbcyc stall", bus.stall_id, 1'b1);
        check("mc fwd11", bus.fwd_sel[1:0], 2'b11);
        step("raw_wb");
        bus.mc_wb = 0;
        #1 check("raw released", bus.stall_id, 1'b0);
        step("raw_c");

        // Fill to MAX_MC, structural stall with same-cycle writeback
        for (int r = 1; r <= MAX_MC; r++) begin
            set_issue(r);
            step($sformatf("fill%0d", r));
        end
        check("full cnt", bus.mc_count, MAX_MC);
        set_issue(5);
        step("struct_a");
        bus.mc_wb = 1; bus.mc_wb_rd = 1;
        #1 check("struct wb stall", bus.stall_id, 1'b1);
        step("struct_b");
        check("struct cnt3", bus.mc_count, 3);
        bus.mc_wb = 0;
        #1 check("struct go", bus.stall_id, 1'b0);
        step("struct_c");
        for (int r = 2; r <= 5; r++) begin
            idle();
            bus.mc_wb = 1; bus.mc_wb_rd = AW'(r);
            step($sformatf("drain%0d", r));
        end
        check("drained", bus.mc_count, 0);

        // Protocol errors and reset
        idle();
        bus.mc_wb = 1; bus.mc_wb_rd = 0;
        step("err_a");
        check("err set", bus.err, 1'b1);
        idle();
        step("err_sticky");
        set_issue(12);
        step("err_iss");
        idle();
        bus.mc_wb = 1; bus.mc_wb_rd = 13;
        step("err_notbusy");
        check("err nb cnt", bus.mc_count, 1);
        do_reset("rst_mid");
        check("rst err", bus.err, 1'b0);
        idle();
        bus.mc_wb = 1; bus.mc_wb_rd = 12;
        step("stale_wb");
        check("stale err", bus.err, 1'b1);

        // Counter saturation
        idle();
        bus.id_valid = 1; bus.id_ex_memread = 1; bus.id_ex_rd = 4;
        bus.id_rs = {5'd0, 5'd4}; bus.id_rs_used = 2'b01;
        for (int k = 0; k < SAT + 4; k++) step($sformatf("sat%0d", k));
        check("sat value", bus.stall_cnt, SAT);

        // Randomized traffic
        do_reset("rnd_start");
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            bus.id_valid        = ($urandom_range(0, 3) != 0);
            bus.id_rs           = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            bus.id_rs_used      = 2'($urandom_range(0, 3));
            bus.id_rd           = AW'($urandom_range(0, 7));
            bus.id_regwrite     = 1'($urandom_range(0, 1));
            bus.id_is_mc        = ($urandom_range(0, 2) == 0);
            bus.ex_rs           = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            bus.id_ex_rd        = AW'($urandom_range(0, 7));
            bus.id_ex_memread   = ($urandom_range(0, 3) == 0);
            bus.ex_mem_rd       = AW'($urandom_range(0, 7));
            bus.ex_mem_regwrite = 1'($urandom_range(0, 1));
            bus.mem_wb_rd       = AW'($urandom_range(0, 7));
            bus.mem_wb_regwrite = 1'($urandom_range(0, 1));
            bus.mc_wb           = ($urandom_range(0, 2) == 0);
            bus.mc_wb_rd        = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                int start;
                start = $urandom_range(0, 7);
                for (int k = 0; k < 8; k++)
                    if (m_busy[(start + k) % 8]) begin
                        bus.mc_wb_rd = AW'((start + k) % 8);
                        break;
                    end
            end
            step($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2: number of source-register read ports per instruction.
REQ-002 Parameter AW, default 5: register-address width; register file holds 2^AW registers; register 0 is hardwired zero.
REQ-003 Parameter MAX_MC, default 4: maximum outstanding multicycle (mul/div) operations.
REQ-004 Parameter CW, default 16: width of the stall performance counter.
REQ-005 Reset is asynchronous and active-low; one clock.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 id_valid  in  1  valid instruction in ID.
REQ-009 id_rs  in  NUM_SRC*AW  ID source addresses; port i occupies bits [i*AW +: AW].
REQ-010 id_rs_used  in  NUM_SRC  bit i set when ID instruction reads id_rs port i.
REQ-011 id_rd, id_regwrite, id_is_mc  in  AW,1,1  ID destination, write enable, multicycle-op flag.
REQ-012 ex_rs  in  NUM_SRC*AW  EX-stage source addresses, same packing.
REQ-013 id_ex_rd, id_ex_memread  in  AW,1  destination and load flag of the instruction in EX.
REQ-014 ex_mem_rd, ex_mem_regwrite  in  AW,1  MEM-stage destination and write enable.
REQ-015 mem_wb_rd, mem_wb_regwrite  in  AW,1  WB-stage destination and write enable.
REQ-016 mc_wb, mc_wb_rd  in  1,AW  multicycle unit writes back result to mc_wb_rd this cycle.
REQ-017 fwd_sel  out  2*NUM_SRC  per-EX-port mux select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 multicycle result.
REQ-018 stall_id  out  1  hold PC and IF/ID.
REQ-019 bubble_ex  out  1  insert NOP into ID/EX; always equal to stall_id.
REQ-020 busy_vec  out  2^AW  scoreboard, bit r set while register r awaits a multicycle result.
REQ-021 mc_count  out  clog2(MAX_MC+1)  outstanding multicycle operations.
REQ-022 stall_cnt  out  CW  stalled-cycle counter.
REQ-023 err  out  1  sticky protocol-error flag.

Function
REQ-024 Forwarding, per EX port i, combinational; register 0 never forwarded: ex_mem_regwrite and ex_mem_rd==ex_rs[i] -> 10; else mc_wb and mc_wb_rd==ex_rs[i] -> 11; else mem_wb_regwrite and mem_wb_rd==ex_rs[i] -> 01; else 00.
REQ-025 Load-use hazard: id_valid, id_ex_memread, id_ex_rd!=0, and id_ex_rd equals any id_rs[i] with id_rs_used[i] set.
REQ-026 RAW scoreboard hazard: id_valid and busy_vec[id_rs[i]] set for any used port i.
REQ-027 WAW hazard: id_valid, id_regwrite, id_rd!=0, busy_vec[id_rd] set.
REQ-028 Structural hazard: id_valid, id_is_mc, mc_count==MAX_MC.
REQ-029 stall_id is the OR of REQ-025..REQ-028, combinational from current inputs and state.
REQ-030 A busy bit cleared by mc_wb in the current cycle still counts as busy for REQ-026/027 in that cycle; no same-cycle bypass into ID.
REQ-031 Issue = id_valid and id_is_mc and id_regwrite and !stall_id; on issue with id_rd!=0, busy_vec[id_rd] sets next edge.
REQ-032 mc_wb clears busy_vec[mc_wb_rd] next edge; busy_vec[0] is constant 0.
REQ-033 mc_count: +1 on issue, -1 on valid mc_wb, unchanged when both occur; issue with id_rd==0 still counts.
REQ-034 Issue blocked at mc_count==MAX_MC even when mc_wb is active that cycle.
REQ-035 mc_wb with mc_count==0, or with mc_wb_rd nonzero and not busy, sets err and changes neither mc_count nor busy_vec.
REQ-036 stall_cnt increments each cycle stall_id is high, saturating at 2^CW-1.

Reset
REQ-037 While rst_n low: busy_vec=0, mc_count=0, stall_cnt=0, err=0, regardless of clk.
REQ-038 Reset mid-operation discards all pending scoreboard entries; later mc_wb for them sets err.

Verification
REQ-039 ex_rs[0]=5, ex_mem_rd=5 and mem_wb_rd=5, both regwrite -> fwd_sel[1:0]=10; ex_mem_regwrite=0 -> 01; ex_rs[0]=0 -> 00.
REQ-040 id_ex_memread=1, id_ex_rd=7, id_rs[1]=7 used -> stall_id=bubble_ex=1, stall_cnt +1; id_rs_used[1]=0 -> no stall.
REQ-041 Issue mc to rd=9; next cycle busy_vec[9]=1, mc_count=1; ID reading x9 stalls until cycle after mc_wb with mc_wb_rd=9; fwd_sel=11 when EX reads x9 during mc_wb.
REQ-042 Issue MAX_MC=4 mc ops to x1..x4 -> mc_count=4; fifth mc stalls; same-cycle mc_wb of x1 -> still stalled, mc_count=3, issue next cycle.
REQ-043 mc_wb with mc_count=0 -> err=1 sticky, mc_count stays 0; rst_n low -> err=0, busy_vec=0 asynchronously.
REQ-044 Hold stall for 2^CW+3 cycles with CW=4 -> stall_cnt saturates at 15.
